// File: rtl/wb_regfile_pkg.sv
// Register file widths and types, shared by decode, writeback and the
// register file itself.
package wb_regfile_pkg;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int PEND_W = 2;

  typedef logic [AW-1:0]     reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [PEND_W-1:0] pend_t;

  localparam reg_addr_t REG_X0   = 5'd0;
  localparam pend_t     PEND_MAX = '1;
endpackage

// File: rtl/wb_regfile_if.sv
// Writeback, read and issue bundle between the pipeline and the register
// file.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic      i_rd_wen;
  reg_addr_t i_rd_waddr;
  xlen_t     i_rd_wdata;
  reg_addr_t i_rs1_raddr;
  reg_addr_t i_rs2_raddr;
  xlen_t     o_rs1_rdata;
  xlen_t     o_rs2_rdata;
  logic      i_issue_valid;
  reg_addr_t i_issue_rd;
  logic      i_issue_use1;
  logic      i_issue_use2;
  logic      o_stall;
  logic      o_sb_err;

  modport master (
    output i_rd_wen, i_rd_waddr, i_rd_wdata,
    output i_rs1_raddr, i_rs2_raddr,
    output i_issue_valid, i_issue_rd,
    output i_issue_use1, i_issue_use2,
    input  o_rs1_rdata, o_rs2_rdata,
    input  o_stall, o_sb_err
  );

  modport slave (
    input  i_rd_wen, i_rd_waddr, i_rd_wdata,
    input  i_rs1_raddr, i_rs2_raddr,
    input  i_issue_valid, i_issue_rd,
    input  i_issue_use1, i_issue_use2,
    output o_rs1_rdata, o_rs2_rdata,
    output o_stall, o_sb_err
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: counts in-flight writes per register and
// blocks issue on RAW hazards or a saturated counter.
module wb_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wb_wen,
  input  reg_addr_t wb_addr,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  input  logic      use1,
  input  logic      use2,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      stall,
  output logic      sb_err
);

  pend_t pend_q [NREGS];
  pend_t pend_d [NREGS];
  logic  err_d;
  logic  wb_fire;
  logic  issue_fire;
  logic  hz1;
  logic  hz2;
  logic  full;
  logic  same;

  assign wb_fire = wb_wen && (wb_addr != REG_X0);

  // A last outstanding write landing this cycle is covered by bypass.
  assign hz1 = use1 && (rs1 != REG_X0) && (pend_q[rs1] != '0)
            && !((pend_q[rs1] == pend_t'(1)) && wb_fire
                 && (wb_addr == rs1));
  assign hz2 = use2 && (rs2 != REG_X0) && (pend_q[rs2] != '0)
            && !((pend_q[rs2] == pend_t'(1)) && wb_fire
                 && (wb_addr == rs2));

  assign full = (issue_rd != REG_X0)
             && (pend_q[issue_rd] == PEND_MAX)
             && !(wb_wen && (wb_addr == issue_rd));

  assign stall      = issue_valid && (hz1 || hz2 || full);
  assign issue_fire = issue_valid && !stall && (issue_rd != REG_X0);
  assign same       = issue_fire && wb_fire && (issue_rd == wb_addr);

  always_comb begin
    pend_d = pend_q;
    err_d  = sb_err;
    if (!same) begin
      if (issue_fire)
        pend_d[issue_rd] = pend_q[issue_rd] + 1'b1;
      if (wb_fire) begin
        if (pend_q[wb_addr] == '0)
          err_d = 1'b1;
        else
          pend_d[wb_addr] = pend_q[wb_addr] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        pend_q[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      pend_q <= pend_d;
      sb_err <= err_d;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Integer register file with write-through read ports and the
// pending-write scoreboard.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  wb_regfile_if.slave  bus
);

  xlen_t regs [NREGS];
  logic  wb_fire;

  assign wb_fire = bus.i_rd_wen && (bus.i_rd_waddr != REG_X0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (wb_fire) begin
      regs[bus.i_rd_waddr] <= bus.i_rd_wdata;
    end
  end

  always_comb begin
    bus.o_rs1_rdata = regs[bus.i_rs1_raddr];
    if (!i_rst_n || (bus.i_rs1_raddr == REG_X0))
      bus.o_rs1_rdata = '0;
    else if (bus.i_rd_wen && (bus.i_rd_waddr == bus.i_rs1_raddr))
      bus.o_rs1_rdata = bus.i_rd_wdata;
  end

  always_comb begin
    bus.o_rs2_rdata = regs[bus.i_rs2_raddr];
    if (!i_rst_n || (bus.i_rs2_raddr == REG_X0))
      bus.o_rs2_rdata = '0;
    else if (bus.i_rd_wen && (bus.i_rd_waddr == bus.i_rs2_raddr))
      bus.o_rs2_rdata = bus.i_rd_wdata;
  end

  wb_scoreboard u_sb (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .wb_wen      (bus.i_rd_wen),
    .wb_addr     (bus.i_rd_waddr),
    .issue_valid (bus.i_issue_valid),
    .issue_rd    (bus.i_issue_rd),
    .use1        (bus.i_issue_use1),
    .use2        (bus.i_issue_use2),
    .rs1         (bus.i_rs1_raddr),
    .rs2         (bus.i_rs2_raddr),
    .stall       (bus.o_stall),
    .sb_err      (bus.o_sb_err)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and random checks of wb_regfile against an array/counter
// model of the register file and scoreboard.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wb_regfile_if bus ();

  wb_regfile dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] m_regs [32];
  int          m_pend [32];
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input int a);
    if (!rst_n || a == 0) return 32'h0;
    if (bus.i_rd_wen && int'(bus.i_rd_waddr) == a) return bus.i_rd_wdata;
    return m_regs[a];
  endfunction

  function automatic bit m_hz(input bit u, input int rs);
    bit wb_here;
    wb_here = bus.i_rd_wen && int'(bus.i_rd_waddr) == rs;
    if (!u || rs == 0 || m_pend[rs] == 0) return 1'b0;
    return !(m_pend[rs] == 1 && wb_here);
  endfunction

  function automatic bit m_stall();
    int  ird;
    bit  full;
    ird  = int'(bus.i_issue_rd);
    full = ird != 0 && m_pend[ird] == 3
        && !(bus.i_rd_wen && int'(bus.i_rd_waddr) == ird);
    return bus.i_issue_valid
        && (m_hz(bus.i_issue_use1, int'(bus.i_rs1_raddr))
         || m_hz(bus.i_issue_use2, int'(bus.i_rs2_raddr))
         || full);
  endfunction

  task automatic drive(input bit wen, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2, input bit iv,
                       input logic [4:0] ird, input bit u1, input bit u2);
    bus.i_rd_wen      = wen;
    bus.i_rd_waddr    = wa;
    bus.i_rd_wdata    = wd;
    bus.i_rs1_raddr   = r1;
    bus.i_rs2_raddr   = r2;
    bus.i_issue_valid = iv;
    bus.i_issue_rd    = ird;
    bus.i_issue_use1  = u1;
    bus.i_issue_use2  = u2;
  endtask

  // One cycle: drive at negedge, check mid-low phase, commit at posedge.
  task automatic step(input string tag, input bit wen, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] r1,
                      input logic [4:0] r2, input bit iv,
                      input logic [4:0] ird, input bit u1, input bit u2);
    bit st, ifire, wfire;
    int a, d;
    drive(wen, wa, wd, r1, r2, iv, ird, u1, u2);
    #1;
    st = m_stall();
    chk({tag, ".rs1"}, bus.o_rs1_rdata, m_read(int'(r1)));
    chk({tag, ".rs2"}, bus.o_rs2_rdata, m_read(int'(r2)));
    chk({tag, ".stall"}, 32'(bus.o_stall), 32'(st));
    chk({tag, ".err"}, 32'(bus.o_sb_err), 32'(m_err));
    @(posedge clk);
    a = int'(wa);
    d = int'(ird);
    ifire = iv && !st && d != 0;
    wfire = wen && a != 0;
    if (wfire) m_regs[a] = wd;
    if (!(ifire && wfire && a == d)) begin
      if (ifire) m_pend[d]++;
      if (wfire) begin
        if (m_pend[a] == 0) m_err = 1'b1;
        else m_pend[a]--;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int q[$];
    logic [4:0] wa;
    bit wen;
    m_reset();
    drive(1'b1, 5'd5, 32'hFFFF_0000, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_read_bypass", bus.o_rs1_rdata, 32'h0);
    chk("rst_stall", 32'(bus.o_stall), 32'h0);
    chk("rst_err", 32'(bus.o_sb_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      step("rst_all", 1'b0, 5'd0, 32'h0, 5'(2*i), 5'(2*i+1),
           1'b0, 5'd0, 1'b0, 1'b0);

    step("wr5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 0, 0, 0, 0);
    step("rd5", 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 0, 0, 0, 0);
    chk("rd5_const", bus.o_rs1_rdata, 32'hDEAD_BEEF);
    step("wr0", 1'b1, 5'd0, 32'h1234, 5'd5, 5'd0, 0, 0, 0, 0);
    step("rd0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 0);

    step("byp7", 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 0, 0, 0, 0);
    step("rd7", 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 0, 0, 0, 0);

    step("iss3", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd3, 0, 0);
    step("raw3", 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1, 5'd0, 1, 0);
    step("raw3_wb", 1'b1, 5'd3, 32'h0BAD_F00D, 5'd3, 5'd0, 1, 5'd0, 1, 0);
    step("rd3", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1, 5'd0, 1, 1);

    for (int i = 0; i < 3; i++)
      step("iss9", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd9, 0, 0);
    step("full9", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd9, 0, 0);
    step("full9_wb", 1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1, 5'd9, 0, 0);
    step("full9_again", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd9, 0, 0);
    for (int i = 0; i < 3; i++)
      step("drain9", 1'b1, 5'd9, 32'(i), 5'd9, 5'd0, 0, 0, 0, 0);

    step("err12", 1'b1, 5'd12, 32'h12, 5'd12, 5'd0, 0, 0, 0, 0);
    step("err_hold", 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 0, 0, 0, 0);
    step("err_hold2", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd4, 0, 0);
    chk("err_set", 32'(bus.o_sb_err), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_err", 32'(bus.o_sb_err), 32'h0);
    chk("async_rd", bus.o_rs1_rdata, 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 5'd4, 32'h44, 5'd5, 5'd12, 1, 5'd0, 1, 1);
    chk("post_rst_err", 32'(bus.o_sb_err), 32'h1);

    m_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      q.delete();
      for (int r = 1; r < 32; r++)
        if (m_pend[r] > 0) q.push_back(r);
      wen = ($urandom_range(0, 9) < 4);
      wa  = 5'd0;
      if (wen && q.size() > 0)
        wa = 5'(q[$urandom_range(0, q.size() - 1)]);
      step("rnd", wen, wa, $urandom, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6),
           5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
